// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-bit pipeline to 16-bit asynchronous SRAM bridge.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int          SRAM_DW        = 16;
  localparam int          SRAM_AW        = 18;
  localparam logic [31:0] BASE_ADDR_DFLT = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses (low half, then high half),
// stretching every half to WAIT_CYCLES+1 cycles and stalling the pipeline via ready.
//
// state | meaning
// IDLE  | waiting for rdEn/wrEn; operation, address and data latched on exit
// LOW   | access to half-word {eff[18:2],0}
// HIGH  | access to half-word {eff[18:2],1}
// DONE  | one-cycle completion, ready=1
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdEn,
  input  logic               wrEn,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam int            CW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               wr_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [SRAM_DW-1:0] rd_lo_q;

  logic [31:0] eff;
  logic        in_access;
  logic        last_cyc;
  logic        unused_eff;

  assign eff        = addr_q - BASE_ADDR;
  assign in_access  = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign last_cyc   = (cnt_q == LAST);
  assign unused_eff = ^{eff[31:19], eff[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_lo_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rdEn || wrEn) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            wr_q    <= wrEn;
            addr_q  <= address;
            wdata_q <= writeData;
          end
        end
        ST_LOW: begin
          if (last_cyc) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
            if (!wr_q) rd_lo_q <= SRAM_DQ;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HIGH: begin
          // both halves commit together so readData never shows a half-updated word
          if (last_cyc) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            if (!wr_q) rdata_q <= {SRAM_DQ, rd_lo_q};
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready     = ((state_q == ST_IDLE) && !rdEn && !wrEn) || (state_q == ST_DONE);
  assign readData  = rdata_q;
  assign SRAM_ADDR = {eff[18:2], state_q == ST_HIGH};
  // the last cycle of each half releases WE_N while address and data are still held
  assign SRAM_WE_N = ~(in_access && wr_q && !last_cyc);
  assign SRAM_OE_N = ~(in_access && !wr_q);
  assign SRAM_DQ   = (in_access && wr_q) ?
                     ((state_q == ST_HIGH) ? wdata_q[31:16] : wdata_q[15:0]) : 'z;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural async SRAM plus a word-level reference of memory contents.
module sram_model (
  input  logic [17:0] addr,
  input  logic        we_n,
  input  logic        oe_n,
  inout  wire  [15:0] dq
);
  logic [15:0] mem [0:262143];

  assign dq = (!oe_n && we_n) ? mem[addr] : 16'bz;

  always @(we_n or addr or dq) begin
    if (!we_n) mem[addr] = dq;
  end
endmodule

module tb_sram_controller;

  localparam int W0 = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en, rd_en1, wr_en1;
  logic [31:0] address, write_data, address1, write_data1;
  logic [31:0] read_data, read_data1;
  logic        ready, ready1;
  wire  [15:0] dq, dq1;
  logic [17:0] sram_addr, sram_addr1;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;
  logic        we_n1, oe_n1, ce_n1, ub_n1, lb_n1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ref_mem [int];
  logic [31:0] exp_rd;

  logic        tr_we   [0:63];
  logic        tr_oe   [0:63];
  logic [17:0] tr_addr [0:63];
  logic [15:0] tr_dq   [0:63];

  always #5 clk = ~clk;

  pullup pu0 (dq);
  pullup pu1 (dq1);

  sram_controller #(.WAIT_CYCLES(W0), .BASE_ADDR(32'd1024)) u_dut (
    .clk(clk), .rst(rst), .rdEn(rd_en), .wrEn(wr_en), .address(address),
    .writeData(write_data), .readData(read_data), .ready(ready), .SRAM_DQ(dq),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  sram_model u_mem (.addr(sram_addr), .we_n(we_n), .oe_n(oe_n), .dq(dq));

  sram_controller #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) u_dut1 (
    .clk(clk), .rst(rst), .rdEn(rd_en1), .wrEn(wr_en1), .address(address1),
    .writeData(write_data1), .readData(read_data1), .ready(ready1), .SRAM_DQ(dq1),
    .SRAM_ADDR(sram_addr1), .SRAM_WE_N(we_n1), .SRAM_OE_N(oe_n1), .SRAM_CE_N(ce_n1),
    .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1)
  );

  sram_model u_mem1 (.addr(sram_addr1), .we_n(we_n1), .oe_n(oe_n1), .dq(dq1));

  function automatic logic [17:0] half_addr(input logic [31:0] a, input logic hi);
    logic [31:0] e;
    e = a - 32'd1024;
    return {e[18:2], hi};
  endfunction

  function automatic void preload(input logic [17:0] ha, input logic [15:0] v);
    u_mem.mem[ha] = v;
    ref_mem[int'(ha)] = v;
  endfunction

  // Drives one request starting at the current cycle and returns cycles until ready.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int cyc, output logic [31:0] rdat);
    bit done;
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    cyc = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc < 64) begin
        tr_we[cyc] = we_n; tr_oe[cyc] = oe_n; tr_addr[cyc] = sram_addr; tr_dq[cyc] = dq;
      end
      if (ready) done = 1;
      else if (cyc >= 40) begin
        n_checks++; n_fail++;
        $display("FAIL access_timeout got=%0d cycles required<40", cyc);
        done = 1;
      end
    end
    rdat = read_data;
    @(posedge clk); #1;
  endtask

  task automatic access1(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int cyc, output bit we_seen);
    bit done;
    rd_en1 = rd; wr_en1 = wr; address1 = a; write_data1 = d;
    cyc = 0; done = 0; we_seen = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (!we_n1) we_seen = 1;
      if (ready1) done = 1;
      else if (cyc >= 40) begin
        n_checks++; n_fail++;
        $display("FAIL access1_timeout got=%0d cycles required<40", cyc);
        done = 1;
      end
    end
    @(posedge clk); #1;
    rd_en1 = 0; wr_en1 = 0;
  endtask

  task automatic idle(input int n);
    rd_en = 0; wr_en = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    int cyc; logic [31:0] rdat;
    rst = 1; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    rd_en1 = 0; wr_en1 = 0; address1 = 0; write_data1 = 0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", ready); end
    n_checks++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", read_data); end
    n_checks++; if ({we_n, oe_n} !== 2'b11) begin n_fail++; $display("FAIL rst_we_oe got=%b exp=11", {we_n, oe_n}); end
    n_checks++; if ({ce_n, ub_n, lb_n} !== 3'b000) begin n_fail++; $display("FAIL rst_ce_ub_lb got=%b exp=000", {ce_n, ub_n, lb_n}); end
    n_checks++; if (dq !== 16'hFFFF) begin n_fail++; $display("FAIL rst_dq_z got=%h exp=released", dq); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    preload(half_addr(32'd1056, 0), 16'h1111);
    preload(half_addr(32'd1056, 1), 16'h2222);
    access(1, 0, 32'd1056, 32'h0, cyc, rdat);
    idle(1);
    exp_rd = 32'h2222_1111;
    n_checks++; if (rdat !== exp_rd) begin n_fail++; $display("FAIL prime_read got=%h exp=%h", rdat, exp_rd); end

    wr_en = 1; address = 32'd1024; write_data = 32'h1234_5A5A;
    @(posedge clk);
    #3;
    n_checks++; if (we_n !== 1'b0) begin n_fail++; $display("FAIL pre_rst_we got=%b exp=0", we_n); end
    rst = 1;
    #1;
    exp_rd = 32'h0;
    n_checks++; if (we_n !== 1'b1) begin n_fail++; $display("FAIL midrst_we got=%b exp=1", we_n); end
    n_checks++; if (dq !== 16'hFFFF) begin n_fail++; $display("FAIL midrst_dq_z got=%h exp=released", dq); end
    n_checks++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata got=%h exp=0", read_data); end
    wr_en = 0;
    @(negedge clk); rst = 0;
    @(negedge clk);
    n_checks++; if ({ready, oe_n, we_n} !== 3'b111) begin n_fail++; $display("FAIL post_rst_idle got=%b exp=111", {ready, oe_n, we_n}); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    int cyc, pos, hf; logic [31:0] rdat; bit in_half;
    access(0, 1, 32'd1024, 32'hDEADBEEF, cyc, rdat);
    idle(1);
    ref_mem[0] = 16'hBEEF; ref_mem[1] = 16'hDEAD;
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL wr_latency got=%0d exp=6", cyc); end
    n_checks++; if (u_mem.mem[0] !== 16'hBEEF) begin n_fail++; $display("FAIL wr_mem0 got=%h exp=beef", u_mem.mem[0]); end
    n_checks++; if (u_mem.mem[1] !== 16'hDEAD) begin n_fail++; $display("FAIL wr_mem1 got=%h exp=dead", u_mem.mem[1]); end
    for (int c = 1; c <= 6; c++) begin
      in_half = (c >= 2) && (c <= 2 * W0 + 3);
      pos = in_half ? (c - 2) % (W0 + 1) : 0;
      hf  = in_half ? (c - 2) / (W0 + 1) : 0;
      n_checks++;
      if (tr_we[c] !== !(in_half && pos != W0)) begin
        n_fail++; $display("FAIL wr_we_c%0d got=%b exp=%b", c, tr_we[c], !(in_half && pos != W0));
      end
      n_checks++;
      if (tr_oe[c] !== 1'b1) begin n_fail++; $display("FAIL wr_oe_c%0d got=%b exp=1", c, tr_oe[c]); end
      if (in_half) begin
        n_checks++;
        if (tr_addr[c] !== 18'(hf)) begin n_fail++; $display("FAIL wr_addr_c%0d got=%h exp=%h", c, tr_addr[c], hf); end
        n_checks++;
        if (tr_dq[c] !== (hf == 1 ? 16'hDEAD : 16'hBEEF)) begin
          n_fail++; $display("FAIL wr_dq_c%0d got=%h exp=%h", c, tr_dq[c], (hf == 1 ? 16'hDEAD : 16'hBEEF));
        end
      end
    end
    access(1, 0, 32'd1024, 32'h0, cyc, rdat);
    idle(1);
    exp_rd = 32'hDEADBEEF;
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL rd_latency got=%0d exp=6", cyc); end
    n_checks++; if (rdat !== exp_rd) begin n_fail++; $display("FAIL rd_data got=%h exp=%h", rdat, exp_rd); end
    for (int c = 1; c <= 6; c++) begin
      in_half = (c >= 2) && (c <= 2 * W0 + 3);
      n_checks++;
      if ({tr_oe[c], tr_we[c]} !== {!in_half, 1'b1}) begin
        n_fail++; $display("FAIL rd_oe_we_c%0d got=%b exp=%b", c, {tr_oe[c], tr_we[c]}, {!in_half, 1'b1});
      end
    end
  endtask

  task automatic test_simultaneous;
    int cyc; logic [31:0] rdat;
    access(1, 1, 32'd1032, 32'h12345678, cyc, rdat);
    idle(1);
    ref_mem[4] = 16'h5678; ref_mem[5] = 16'h1234;
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL both_latency got=%0d exp=6", cyc); end
    n_checks++; if (u_mem.mem[4] !== 16'h5678) begin n_fail++; $display("FAIL both_mem4 got=%h exp=5678", u_mem.mem[4]); end
    n_checks++; if (u_mem.mem[5] !== 16'h1234) begin n_fail++; $display("FAIL both_mem5 got=%h exp=1234", u_mem.mem[5]); end
    n_checks++; if (read_data !== exp_rd) begin n_fail++; $display("FAIL both_rdata_held got=%h exp=%h", read_data, exp_rd); end
  endtask

  task automatic test_dropped;
    int cyc; bit done;
    rd_en = 1; address = 32'd1024; cyc = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (ready) done = 1;
      else if (cyc >= 40) begin
        n_checks++; n_fail++; $display("FAIL drop_timeout got=%0d required<40", cyc); done = 1;
      end else if (cyc == 2) begin
        @(posedge clk); #1; rd_en = 0;
      end
    end
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL drop_latency got=%0d exp=6", cyc); end
    n_checks++; if (read_data !== exp_rd) begin n_fail++; $display("FAIL drop_rdata got=%h exp=%h", read_data, exp_rd); end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if ({ready, oe_n} !== 2'b11) begin n_fail++; $display("FAIL drop_idle_after got=%b exp=11", {ready, oe_n}); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc1, cyc2; logic [31:0] r1, r2, d;
    preload(18'd2, 16'hC0DE);
    preload(18'd3, 16'hF00D);
    access(1, 0, 32'd1024, 32'h0, cyc1, r1);
    access(1, 0, 32'd1028, 32'h0, cyc2, r2);
    idle(1);
    exp_rd = 32'hF00DC0DE;
    n_checks++; if (cyc1 !== 6 || cyc2 !== 6) begin n_fail++; $display("FAIL b2b_latency got=%0d,%0d exp=6,6", cyc1, cyc2); end
    n_checks++; if (r1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_first got=%h exp=deadbeef", r1); end
    n_checks++; if (r2 !== exp_rd) begin n_fail++; $display("FAIL b2b_second got=%h exp=%h", r2, exp_rd); end

    d = $urandom;
    access(0, 1, 32'd1020, d, cyc1, r1);
    idle(1);
    ref_mem[int'(18'h3FFFE)] = d[15:0]; ref_mem[int'(18'h3FFFF)] = d[31:16];
    n_checks++; if (tr_addr[2] !== 18'h3FFFE) begin n_fail++; $display("FAIL wrap_addr_lo got=%h exp=3fffe", tr_addr[2]); end
    n_checks++; if (tr_addr[4] !== 18'h3FFFF) begin n_fail++; $display("FAIL wrap_addr_hi got=%h exp=3ffff", tr_addr[4]); end
    n_checks++;
    if ({u_mem.mem[18'h3FFFF], u_mem.mem[18'h3FFFE]} !== d) begin
      n_fail++; $display("FAIL wrap_mem got=%h exp=%h", {u_mem.mem[18'h3FFFF], u_mem.mem[18'h3FFFE]}, d);
    end
  endtask

  task automatic test_random;
    int cyc, op, k; logic [31:0] a, d, rdat, e;
    for (int i = 0; i < 16; i++) begin
      preload(half_addr(32'd1024 + 32'(4 * i), 0), 16'($urandom));
      preload(half_addr(32'd1024 + 32'(4 * i), 1), 16'($urandom));
    end
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      k  = $urandom_range(0, 15);
      a  = 32'd1024 + 32'(4 * k);
      d  = $urandom;
      access(op != 1, op != 0, a, d, cyc, rdat);
      idle($urandom_range(0, 2));
      n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL rnd_latency t=%0d got=%0d exp=6", t, cyc); end
      if (op == 0) begin
        e = {ref_mem[int'(half_addr(a, 1))], ref_mem[int'(half_addr(a, 0))]};
        exp_rd = e;
        n_checks++; if (rdat !== e) begin n_fail++; $display("FAIL rnd_read t=%0d got=%h exp=%h", t, rdat, e); end
      end else begin
        ref_mem[int'(half_addr(a, 0))] = d[15:0];
        ref_mem[int'(half_addr(a, 1))] = d[31:16];
        n_checks++; if (rdat !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata_held t=%0d got=%h exp=%h", t, rdat, exp_rd); end
      end
    end
    for (int h = 0; h < 32; h++) begin
      n_checks++;
      if (u_mem.mem[h] !== ref_mem[h]) begin
        n_fail++; $display("FAIL rnd_mem h=%0d got=%h exp=%h", h, u_mem.mem[h], ref_mem[h]);
      end
    end
  endtask

  task automatic test_wait0;
    int cyc; bit we_seen;
    u_mem1.mem[0] = 16'hAAAA; u_mem1.mem[1] = 16'h5555;
    access1(0, 1, 32'd1032, 32'hCAFEF00D, cyc, we_seen);
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL w0_wr_latency got=%0d exp=4", cyc); end
    n_checks++; if (we_seen !== 1'b0) begin n_fail++; $display("FAIL w0_we_in_hold got=%b exp=0", we_seen); end
    access1(1, 0, 32'd1024, 32'h0, cyc, we_seen);
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL w0_rd_latency got=%0d exp=4", cyc); end
    n_checks++; if (read_data1 !== 32'h5555AAAA) begin n_fail++; $display("FAIL w0_rd_data got=%h exp=5555aaaa", read_data1); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_dropped();
    test_back_to_back();
    test_random();
    test_wait0();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, 1, extra hold cycles per 16-bit SRAM access half (each half lasts WAIT_CYCLES+1 cycles).
REQ-002 Parameter BASE_ADDR, 1024, data-memory base subtracted from the pipeline address.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port rdEn  input  1  memory read request from the MEM stage, level-held until ready.
REQ-006 Port wrEn  input  1  memory write request from the MEM stage, level-held until ready.
REQ-007 Port address  input  32  byte address, word-aligned.
REQ-008 Port writeData  input  32  store data.
REQ-009 Port readData  output  32  registered load data, valid when ready=1 after a read.
REQ-010 Port ready  output  1  low freezes the pipeline; high means the request has completed or no request is pending.
REQ-011 Port SRAM_DQ  inout  16  SRAM data bus.
REQ-012 Port SRAM_ADDR  output  18  SRAM half-word address.
REQ-013 Ports SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  active-low SRAM controls.

Function
REQ-014 FSM states SHALL be IDLE, LOW, HIGH and DONE.
REQ-015 IDLE SHALL go to LOW when rdEn|wrEn; otherwise it SHALL stay in IDLE.
REQ-016 LOW SHALL go to HIGH, and HIGH SHALL go to DONE, each after WAIT_CYCLES+1 cycles counted by a wait counter cleared on each state entry.
REQ-017 DONE SHALL go to IDLE unconditionally after 1 cycle.
REQ-018 ready SHALL be combinational: 1 in IDLE with rdEn=wrEn=0, 1 in DONE, 0 otherwise.
REQ-019 Latency SHALL be a request cycle in IDLE, plus 2*(WAIT_CYCLES+1) cycles, plus DONE; with the default, ready first rises in cycle 6, counting the request cycle as cycle 1.
REQ-020 The operation SHALL be latched on leaving IDLE; if wrEn and rdEn are both high, write SHALL win.
REQ-021 Request inputs that change after leaving IDLE SHALL be ignored, and the operation SHALL complete in full.
REQ-022 Effective address SHALL be eff = address - BASE_ADDR, computed mod 2^32.
REQ-023 SRAM_ADDR SHALL be {eff[18:2],1'b0} in LOW and {eff[18:2],1'b1} in HIGH; eff[1:0] SHALL be ignored.
REQ-024 For a write, SRAM_WE_N SHALL be 0 on every LOW/HIGH cycle except the last cycle of each half, which gives the address/data hold.
REQ-025 For a write, SRAM_DQ SHALL drive writeData[15:0] in LOW and writeData[31:16] in HIGH.
REQ-026 For a read, SRAM_OE_N SHALL be 0 in LOW/HIGH.
REQ-027 For a read, SRAM_DQ SHALL be sampled into readData[15:0] on the last LOW cycle and into readData[31:16] on the last HIGH cycle.
REQ-028 Outside a write in LOW/HIGH, SRAM_DQ SHALL be high-Z, SRAM_WE_N=1 and, except during reads, SRAM_OE_N=1.
REQ-029 SRAM_CE_N, SRAM_UB_N and SRAM_LB_N SHALL be held 0.
REQ-030 readData SHALL hold its value until the next read completes; a write SHALL NOT alter it.
REQ-031 A new request present in the cycle after DONE SHALL start a new access, with no back-to-back merging.

Reset
REQ-032 rst SHALL force IDLE, wait counter 0, readData 0, SRAM_WE_N=1, SRAM_OE_N=1 and SRAM_DQ high-Z immediately, with no clock needed.
REQ-033 rst asserted mid-operation SHALL abort the access; ready SHALL be 1 after release if no request is pending.

Structure
REQ-034 A shared package SHALL hold the state encoding, SRAM_DW=16, SRAM_AW=18 and the BASE_ADDR default.
REQ-035 No RTL sub-module is required; the bench SHALL use a behavioural sub-module sram_model, a 2^18 x 16 array with async read and write on WE_N low.

Verification
REQ-036 Reset check: assert rst mid-LOW during a write -> SRAM_WE_N=1, SRAM_DQ=Z and readData=0 in the same cycle; IDLE after release.
REQ-037 Write then read: write address=1024, data=0xDEADBEEF -> model[0]=0xBEEF and model[1]=0xDEAD; ready=1 in cycle 6; then read 1024 -> readData=0xDEADBEEF in the DONE cycle.
REQ-038 Simultaneous request: rdEn=wrEn=1, address=1032, data=0x12345678 -> a write occurs (model[4]=0x5678), and readData is unchanged.
REQ-039 Dropped request: rdEn deasserted in the second LOW cycle -> the access still completes and ready pulses in DONE.
REQ-040 Back-to-back and wrap: read 1024 then immediately read 1028 -> two separate 6-cycle accesses; address=1020 -> eff wraps and SRAM_ADDR={eff[18:2],half} = 0x3FFFE/0x3FFFF.
REQ-041 Parameter check: WAIT_CYCLES=0 -> ready in cycle 4, and SRAM_WE_N is never asserted in a hold cycle.
